state_cmd_gen: RTL

Command generator that drives the 4-bit set/clear state register. It accepts an absolute target state and emits the minimal sequence of single-bit commands that walks the register from its current value to the target. Each command is a `data`/`sel` pair: `data=1` sets bit `sel`, `data=0` clears it. The block keeps a shadow copy of the register so it only issues commands for bits that differ. It sits upstream of the state register and shares its clock and reset.

---
 rtl/state_cmd_pkg.sv | 18 +
 rtl/lsb_prio_enc.sv | 24 ++
 rtl/state_cmd_gen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/state_cmd_pkg.sv
// state_cmd_pkg: shared types and defaults for the state command generator.
//   gen_state_t : FSM state encoding (IDLE, ISSUE, DONE)
//   NBITS_DEF   : default width of the controlled state register
//   SELW_DEF    : default width of a bit index into that register
//   bit_cmd_t   : one single-bit set/clear command (data, sel)
package state_cmd_pkg;

  localparam int NBITS_DEF = 4;
  localparam int SELW_DEF  = $clog2(NBITS_DEF);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} gen_state_t;

  typedef struct packed {
    logic                data;
    logic [SELW_DEF-1:0] sel;
  } bit_cmd_t;

endpackage

// File: rtl/lsb_prio_enc.sv
// lsb_prio_enc: combinational lowest-set-bit encoder.
//   vec : input vector
//   idx : index of the lowest set bit of vec (0 when vec is zero)
//   any : high when at least one bit of vec is set
module lsb_prio_enc #(
  parameter int NBITS = 4,
  parameter int SELW  = $clog2(NBITS)
) (
  input  logic [NBITS-1:0] vec,
  output logic [SELW-1:0]  idx,
  output logic             any
);

  // Scan from the top down so the last hit, i.e. the lowest bit, wins.
  always_comb begin
    idx = '0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (vec[i]) idx = SELW'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/state_cmd_gen.sv
// state_cmd_gen: walks a set/clear state register from its current value to
// an absolute target using the minimal set of single-bit commands, issued in
// ascending bit order.
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : target request valid
//   req_target  : requested absolute state
//   req_ready   : request can be accepted (IDLE only)
//   cmd_valid   : command valid
//   cmd_data    : 1 = set bit cmd_sel, 0 = clear it
//   cmd_sel     : bit index addressed by the command
//   cmd_ready   : downstream accepts the command
//   done        : one-cycle pulse once the target is reached
//   shadow      : tracked copy of the downstream register
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid-side payload is held stable until that edge.
// The FSM state is held in 'state' (gen_state_t) for debug visibility.
module state_cmd_gen
  import state_cmd_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int SELW  = $clog2(NBITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [NBITS-1:0] req_target,
  output logic             req_ready,
  output logic             cmd_valid,
  output logic             cmd_data,
  output logic [SELW-1:0]  cmd_sel,
  input  logic             cmd_ready,
  output logic             done,
  output logic [NBITS-1:0] shadow
);

  gen_state_t       state;
  logic [NBITS-1:0] tgt;
  logic [NBITS-1:0] pend;

  logic [NBITS-1:0] diff;
  logic [NBITS-1:0] first_src;
  logic [NBITS-1:0] pend_masked;
  logic [SELW-1:0]  first_idx;
  logic             first_any;
  logic [SELW-1:0]  next_idx;
  logic             next_any;

  assign diff = req_target ^ shadow;

  // In IDLE the pending set is not latched yet, so the first command is
  // looked up straight from the incoming difference.
  assign first_src = (state == IDLE) ? diff : pend;

  // Lookahead: pending bits with the command currently on the bus removed,
  // so the next command can be loaded in the same edge as the handshake.
  assign pend_masked = pend & ~(NBITS'(1) << cmd_sel);

  lsb_prio_enc #(.NBITS(NBITS), .SELW(SELW)) u_enc_first (
    .vec (first_src),
    .idx (first_idx),
    .any (first_any)
  );

  lsb_prio_enc #(.NBITS(NBITS), .SELW(SELW)) u_enc_next (
    .vec (pend_masked),
    .idx (next_idx),
    .any (next_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tgt       <= '0;
      pend      <= '0;
      shadow    <= '0;
      req_ready <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_data  <= 1'b0;
      cmd_sel   <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            tgt       <= req_target;
            pend      <= diff;
            req_ready <= 1'b0;
            if (!first_any) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              cmd_valid <= 1'b1;
              cmd_sel   <= first_idx;
              cmd_data  <= req_target[first_idx];
            end
          end
        end

        ISSUE: begin
          if (cmd_valid && cmd_ready) begin
            shadow[cmd_sel] <= cmd_data;
            pend[cmd_sel]   <= 1'b0;
            if (next_any) begin
              cmd_sel  <= next_idx;
              cmd_data <= tgt[next_idx];
            end else begin
              cmd_valid <= 1'b0;
              state     <= DONE;
              done      <= 1'b1;
            end
          end
        end

        DONE: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          cmd_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
